mmio_param_fifo: RTL

- Parametrised synchronous FIFO; successor to the fixed single-enable FIFO behind the AFU's MMIO user register.
- Adds independent push/pop handshakes, occupancy count, full/empty flags and sticky overflow/underflow error flags.
- Adds flush, and an overwrite mode in which a push to a full FIFO discards the oldest entry.
- Sits between the CCI-P MMIO write decode (push) and the MMIO read mux (pop/readback), one instance per channel.

---
 rtl/mmio_param_fifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mmio_param_fifo.sv
// Parametrised synchronous FIFO for an MMIO user-register channel.
// The write-decode side pushes entries and the read mux pops them.
// Provides occupancy, full/empty, sticky error flags, flush and an optional
// overwrite-oldest mode.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   push, push_data     write request and its data
//   pop                 read request
//   pop_data, pop_valid registered read data and its one-cycle valid pulse
//   flush               synchronous clear of contents (wins over push/pop)
//   clr_err             synchronous clear of the sticky error flags
//   full, empty, count  occupancy status decoded from the count register
//   overflow, underflow sticky flags: rejected push / rejected pop
module mmio_param_fifo #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 8,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   pop_valid,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  logic pop_ok;
  logic push_ok;
  logic drop;
  logic ovf_set;
  logic udf_set;

  // Status is a pure decode of the count register.
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // Request qualification; flush suppresses every request and error event.
  // drop marks an overwrite-mode push into a full FIFO that evicts the oldest.
  always_comb begin
    pop_ok  = pop && !empty && !flush;
    udf_set = pop && empty && !flush;
    push_ok = 1'b0;
    drop    = 1'b0;
    ovf_set = 1'b0;
    if (push && !flush) begin
      if (!full || pop_ok) begin
        push_ok = 1'b1;
      end else if (OVERWRITE) begin
        push_ok = 1'b1;
        drop    = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, read data and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        pop_valid <= 1'b0;
      end else begin
        pop_valid <= pop_ok;
        if (pop_ok) begin
          // When full, wr_ptr == rd_ptr: the old entry is read before the
          // same-edge push overwrites that slot.
          pop_data <= mem[rd_ptr];
        end
        if (push_ok) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_ok || drop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push_ok && !pop_ok && !drop) begin
          cnt <= cnt + CW'(1);
        end else if (pop_ok && !push_ok) begin
          cnt <= cnt - CW'(1);
        end
      end
      // A new error event wins over a same-cycle clear.
      overflow  <= ovf_set || (overflow && !clr_err);
      underflow <= udf_set || (underflow && !clr_err);
    end
  end

endmodule
